// File: rtl/pixel_frame_assembler_if.sv
// pixel_frame_assembler_if: pixel stream in, flattened frame out, with consumer ack
interface pixel_frame_assembler_if #(parameter int resolution = 8, parameter int matrix_side_length = 28);
  localparam int n = matrix_side_length ** 2;
  logic [resolution-1:0] pixel_in;
  logic pixel_valid;
  logic start_of_frame;
  logic pixel_ready;
  logic [n*resolution-1:0] frame_pixels;
  logic frame_valid;
  logic frame_ack;
  logic frame_restart;
  modport master (output pixel_in, pixel_valid, start_of_frame, frame_ack, input pixel_ready, frame_pixels, frame_valid, frame_restart);
  modport slave (input pixel_in, pixel_valid, start_of_frame, frame_ack, output pixel_ready, frame_pixels, frame_valid, frame_restart);
endinterface

// File: rtl/pixel_frame_assembler.sv
// pixel_frame_assembler: captures a row-major pixel stream into a flattened square frame held until acked
module pixel_frame_assembler #(parameter int resolution = 8, parameter int matrix_side_length = 28) (
  input logic clk,
  input logic reset,
  pixel_frame_assembler_if.slave s
);
  localparam int n = matrix_side_length ** 2;
  localparam int cw = $clog2(n);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t state;
  logic [cw-1:0] count;
  logic [n*resolution-1:0] frame;
  logic restart;
  logic acc;
  logic [cw-1:0] idx;
  assign acc = s.pixel_valid && s.pixel_ready;
  assign idx = s.start_of_frame ? '0 : count;
  assign s.pixel_ready = state != HOLD;
  assign s.frame_valid = state == HOLD;
  assign s.frame_pixels = frame;
  assign s.frame_restart = restart;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      count <= '0;
      frame <= '0;
      restart <= 1'b0;
    end else begin
      restart <= 1'b0;
      // non-start beats in IDLE are dropped without touching the frame
      if (acc && (state == FILL || s.start_of_frame)) frame[resolution*idx +: resolution] <= s.pixel_in;
      case (state)
        IDLE: if (acc && s.start_of_frame) begin
          count <= cw'(1);
          state <= FILL;
        end
        FILL: if (acc) begin
          if (s.start_of_frame) begin
            count <= cw'(1);
            restart <= 1'b1;
          end else if (count == cw'(n - 1)) begin
            count <= '0;
            state <= HOLD;
          end else count <= count + cw'(1);
        end
        HOLD: if (s.frame_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pixel_frame_assembler.sv
// tb_pixel_frame_assembler: directed vector table plus hand-written corner sequences on a 4x4 frame
module tb_pixel_frame_assembler;
  localparam int res = 8;
  localparam int side = 4;
  localparam int n = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int restarts = 0;
  always #5 clk = ~clk;
  pixel_frame_assembler_if #(.resolution(res), .matrix_side_length(side)) s();
  pixel_frame_assembler #(.resolution(res), .matrix_side_length(side)) dut (.clk(clk), .reset(reset), .s(s.slave));
  always @(negedge clk) if (s.frame_restart) restarts++;
  typedef struct {
    logic v;
    logic sof;
    logic ack;
    logic [7:0] pix;
    logic e_ready;
    logic e_valid;
  } vec_t;
  vec_t vecs[23];
  function automatic logic [n*res-1:0] ramp(input logic [7:0] base);
    logic [n*res-1:0] e;
    for (int p = 0; p < n; p++) e[res*p +: res] = base + 8'(p);
    return e;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic check_frame(input string name, input logic [n*res-1:0] exp);
    checks++;
    if (s.frame_pixels !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, s.frame_pixels, exp);
    end
  endtask
  task automatic beat(input logic [7:0] pix, input logic sof);
    int t;
    t = 0;
    s.pixel_valid = 1'b1;
    s.pixel_in = pix;
    s.start_of_frame = sof;
    @(negedge clk);
    while (!s.pixel_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!s.pixel_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=ready0 expected=ready1");
    end
    @(posedge clk);
    #1;
    s.pixel_valid = 1'b0;
    s.start_of_frame = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] base, input logic gaps);
    for (int p = 0; p < n; p++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      if (p == n - 1) check("early_valid", 32'(s.frame_valid), 0);
      beat(base + 8'(p), p == 0);
    end
    check("frame_valid", 32'(s.frame_valid), 1);
    check("hold_ready", 32'(s.pixel_ready), 0);
    check_frame("frame_data", ramp(base));
  endtask
  task automatic ack();
    s.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    s.frame_ack = 1'b0;
    check("ack_valid", 32'(s.frame_valid), 0);
    check("ack_ready", 32'(s.pixel_ready), 1);
  endtask
  initial begin
    int r0;
    s.pixel_in = '0;
    s.pixel_valid = 1'b0;
    s.start_of_frame = 1'b0;
    s.frame_ack = 1'b0;
    for (int i = 0; i < 16; i++) vecs[i] = '{1'b1, i == 0, 1'b0, 8'(i + 1), 1'b1, 1'b0};
    for (int i = 16; i < 21; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(s.pixel_ready), 1);
    check("rst_valid", 32'(s.frame_valid), 0);
    check("rst_restart", 32'(s.frame_restart), 0);
    check_frame("rst_frame", '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 23; i++) begin
      s.pixel_valid = vecs[i].v;
      s.start_of_frame = vecs[i].sof;
      s.frame_ack = vecs[i].ack;
      s.pixel_in = vecs[i].pix;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 32'(s.pixel_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_valid", i), 32'(s.frame_valid), 32'(vecs[i].e_valid));
      if (i >= 16 && i <= 21) check_frame($sformatf("vec%0d_frame", i), ramp(8'h01));
      @(posedge clk);
      #1;
    end
    check("table_restarts", 32'(restarts), 0);
    repeat (3) beat(8'hAA, 1'b0);
    check("discard_valid", 32'(s.frame_valid), 0);
    check_frame("discard_frame", ramp(8'h01));
    send_frame(8'h20, 1'b0);
    ack();
    r0 = restarts;
    for (int i = 0; i < 6; i++) beat(8'h30 + 8'(i), i == 0);
    beat(8'h55, 1'b1);
    for (int i = 1; i < n; i++) begin
      if (i == n - 1) check("restart_early_valid", 32'(s.frame_valid), 0);
      beat(8'h55 + 8'(i), 1'b0);
    end
    check("restart_valid", 32'(s.frame_valid), 1);
    check_frame("restart_frame", ramp(8'h55));
    check("restart_pulses", 32'(restarts - r0), 1);
    ack();
    send_frame(8'h70, 1'b1);
    ack();
    for (int i = 0; i < 9; i++) beat(8'h80 + 8'(i), i == 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_ready", 32'(s.pixel_ready), 1);
    check("async_valid", 32'(s.frame_valid), 0);
    check("async_restart", 32'(s.frame_restart), 0);
    check_frame("async_frame", '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'h90, 1'b0);
    ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_frame_assembler.md
Name: pixel_frame_assembler

Overview:
- Upstream feeder for the pooling stage.
- Accepts a serial, row-major stream of pixels with a valid/ready handshake and writes each pixel into a flattened frame register.
- Once a full square frame is captured, it presents the frame in parallel on frame_pixels, in the same flattened layout the pooling stage consumes, and holds it until the consumer acknowledges.

Parameters:
- resolution, 8, bits per pixel.
- matrix_side_length, 28, side of the square frame. N = matrix_side_length**2 pixels per frame.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pixel_in  input  resolution  incoming pixel value.
- pixel_valid  input  1  pixel_in is valid this cycle.
- start_of_frame  input  1  qualifies pixel_in as pixel 0 of a frame; only meaningful when pixel_valid=1.
- pixel_ready  output  1  block accepts a beat this cycle.
- frame_pixels  output  N*resolution  flattened frame; pixel p (row r, col c, p = r*matrix_side_length + c) occupies bits [resolution*p +: resolution].
- frame_valid  output  1  frame_pixels holds a complete frame.
- frame_ack  input  1  consumer has taken the frame.
- frame_restart  output  1  one-cycle pulse when a frame in progress is abandoned by a new start_of_frame.

Behaviour:
- Beat accepted = pixel_valid & pixel_ready at a rising edge.
- Reset (async assert, released synchronously to clk):
  - state=IDLE, count=0.
  - frame_pixels=0, frame_valid=0, frame_restart=0.
  - pixel_ready=1 once the state is IDLE.
- count width is $clog2(N).
- pixel_ready is combinational from state: 1 in IDLE and FILL, 0 in HOLD.
- IDLE:
  - Accepted beat with start_of_frame=1: write pixel 0, count=1, go to FILL.
  - Accepted beat with start_of_frame=0: discard it; no state change.
- FILL:
  - Accepted beat with start_of_frame=0: write pixel[count], count+1.
  - Accepted beat with start_of_frame=1: write pixel 0, count=1, stay in FILL, pulse frame_restart next cycle. Stale pixels from the abandoned frame remain in the register but are overwritten before frame_valid rises.
  - Accepted beat when count=N-1 (and start_of_frame=0): write the last pixel, count=0, go to HOLD.
  - No beat: hold all state. Gaps in pixel_valid are legal.
- HOLD:
  - frame_valid=1, frame_pixels stable, pixel_ready=0. Stream beats are back-pressured, not dropped.
  - frame_ack=1: go to IDLE; frame_valid=0 and pixel_ready=1 from the next cycle.
- Latency: frame_valid rises on the clock edge that accepts the last pixel, so it is visible the cycle after that beat is presented.
- frame_ack is ignored outside HOLD.
- Throughput: one pixel per cycle in FILL; at least 1 idle cycle (HOLD) between frames.
- A start_of_frame beat arriving in HOLD is simply stalled. Once IDLE, it is accepted as the start of a new frame.
- frame_pixels changes only on accepted beats. The pooling stage may sample it combinationally while frame_valid=1.
- Reset mid-FILL or mid-HOLD: immediate return to reset values; the partial frame is lost.

Test Plan:
- matrix_side_length=4, resolution=8 (N=16). Send beats 0x01..0x10 back-to-back, start_of_frame on the first -> frame_valid=1 the cycle after the 16th beat; frame_pixels[7:0]=0x01, [127:120]=0x10; pixel_ready=0.
- From that HOLD, hold pixel_valid=1 for 5 cycles, then pulse frame_ack -> frame_pixels unchanged throughout; frame_valid=0 and pixel_ready=1 the next cycle.
- In IDLE, send 3 beats 0xAA with start_of_frame=0, then a full frame 0x20..0x2F -> the 0xAA beats are discarded; frame_pixels[7:0]=0x20.
- Send 6 beats, then a start_of_frame beat 0x55 followed by 15 more beats (0x56..0x64) -> frame_restart pulses once; final frame_pixels[7:0]=0x55 and [127:120]=0x64.
- Toggle pixel_valid randomly (about 50% duty) over a frame -> result identical to the back-to-back case; frame_valid only after exactly 16 accepted beats.
- Assert reset asynchronously after 9 beats of a frame -> outputs reach reset values without a clock edge; the next full frame is captured correctly from pixel 0.
